spike_generator_core: RTL and testbench
=======================================

// Module: spike_generator_core
// PURPOSE
//  Bank of 2**NGENS programmable periodic spike generators that feeds tags toward the BD-bound router.
//  Programmed over a SpikeGeneratorProgChannel-style port; configured by SpikeGeneratorConf registers.
//  On each time-unit pulse from the time manager it scans generators 0..gens_used.
//  Each generator whose countdown expires emits one (tag, ct) word on a TagCtChannel-style output.
// PARAMETERS
//  NGENS    8   generator index width; bank holds 2**NGENS generators
//  NPERIOD  16  period/ticks width, in time units
//  NTAG     11  output tag width
//  NCT      9   output count width, two's complement
// PORTS
//  clk            in   1            system clock
//  reset_n        in   1            async active-low reset
//  gens_used      in   NGENS        max generator idx scanned (inclusive)
//  gens_en        in   2**NGENS     per-generator enable
//  time_unit      in   1            1-cycle pulse per FPGA time unit
//  prog_gen_idx   in   NGENS        generator to program
//  prog_period    in   NPERIOD      spike period, units; 0 = never fire
//  prog_ticks     in   NPERIOD      initial countdown
//  prog_tag       in   NTAG         tag emitted
//  prog_sign      in   1            0 -> ct=+1, 1 -> ct=-1
//  prog_v/prog_a  in/out 1/1        program handshake
//  out_tag        out  NTAG         emitted tag
//  out_ct         out  NCT          emitted count
//  out_v/out_a    out/in 1/1        output handshake
//  missed_unit    out  1            sticky: a time unit was dropped
// BEHAVIOUR
//  Handshakes: transfer when v&&a in the same cycle. out_v, out_tag, out_ct stay stable until accepted.
//  Reset (async, any state): out_v=0, out_tag=0, out_ct=0, prog_a=0, missed_unit=0, pending=0; FSM->INIT.
//  FSM states INIT, IDLE, RD, UPD, EMIT:
//   INIT: write all-zero state to entries 0..2**NGENS-1, one per cycle; then IDLE. Reset mid-INIT restarts the sweep.
//   IDLE: if pending -> clear pending, idx=0, RD. Else prog_a=prog_v (combinational).
//         An accepted prog writes {period, ticks, tag, sign} to prog_gen_idx in 1 cycle.
//   RD: issue mem read of idx (1-cycle latency) -> UPD.
//   UPD: skip the generator (state unchanged) if gens_en[idx]==0 or period==0.
//        Else if ticks==0: write ticks=period-1, load out regs, out_v=1 -> EMIT.
//        Else write ticks=ticks-1.
//        Leaving UPD without emitting: idx==gens_used -> IDLE, else idx+1 -> RD.
//   EMIT: hold until out_a; then out_v=0 next cycle; go to IDLE or RD idx+1 per the same rule.
//  Timing: non-firing generator costs 2 cycles; firing adds >=1 cycle (EMIT).
//  Firing period: a generator with period P fires every P units. First fire is at the (ticks+1)th scan after programming.
//  time_unit in IDLE with nothing pending starts the scan next cycle.
//  time_unit while busy or pending: set pending. If pending is already set, set missed_unit (sticky until reset) and drop the unit.
//  time_unit and prog_v together in IDLE: time unit wins; prog_a=0 that cycle.
//  out_ct = sign ? {NCT{1'b1}} : NCT'(1).
//  gens_used, gens_en are sampled at each UPD; changes mid-scan take effect for later indices.
//  Disabled generators keep their phase exactly.
//  gens_used >= 2**NGENS cannot occur (width-limited); gens_used=0 scans generator 0 only.
//  Reprogramming only in IDLE: prog_a=0 in INIT/RD/UPD/EMIT, so no read/write race exists.
// STRUCTURE
//  Package spike_gen_pkg:
//   typedef gen_state_t struct {period, ticks, tag, sign}
//   typedef fsm_state_t enum
//   CT_PLUS, CT_MINUS constants
//  Sub-module spike_gen_mem: 2**NGENS x $bits(gen_state_t) 1R1W RAM, sync read, no reset.
//  Top holds FSM, idx counter, pending/missed flags, output registers.
// TESTING
//  1 Reset release, NGENS=8 -> prog_a=0 for 256 cycles (INIT), then prog_a follows prog_v; out_v=0 throughout.
//  2 Program gen3 {P=4, ticks=1, tag=0x2A, sign=0}, gens_used=3, en[3]=1, pulse every 50 cycles
//      -> emits tag=0x02A, ct=9'h001 on units 2, 6, 10; no other output.
//  3 Same with sign=1, out_a held low 200 cycles -> output stable with ct=9'h1FF.
//      2nd pulse during stall -> pending, scanned after accept; 3rd pulse -> missed_unit=1.
//  4 Gen5 programmed P=1, gens_used=4 -> never emits. gens_used=5 -> emits every unit.
//      Clear en[5] for 3 units, then set it -> resumes with no lost or extra phase.
//  5 Program period=0 -> no emission over 20 units. prog_v together with time_unit in IDLE -> prog_a=0 that cycle; accepted after the scan.
//  6 Assert reset_n low mid-EMIT -> out_v=0 immediately; missed_unit=0; INIT reruns; prior programming is gone (no emissions).

Source files
------------

// File: rtl/spike_gen_pkg.sv
// Shared types and constants for the spike generator bank.
//   gen_state_t : per-generator stored state {period, ticks, tag, sign}
//   fsm_state_t : controller states of spike_generator_core
//   CT_PLUS / CT_MINUS : emitted count values for sign = 0 / 1
//   gen_countdown() : next stored state of an enabled, non-zero-period generator
package spike_gen_pkg;

  localparam int NGENS    = 8;
  localparam int NPERIOD  = 16;
  localparam int NTAG     = 11;
  localparam int NCT      = 9;
  localparam int NUM_GENS = 1 << NGENS;

  typedef struct packed {
    logic [NPERIOD-1:0] period;
    logic [NPERIOD-1:0] ticks;
    logic [NTAG-1:0]    tag;
    logic               sign;
  } gen_state_t;

  localparam int GEN_W = $bits(gen_state_t);

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_RD   = 3'd2,
    ST_UPD  = 3'd3,
    ST_EMIT = 3'd4
  } fsm_state_t;

  localparam logic [NCT-1:0] CT_PLUS  = NCT'(1);
  localparam logic [NCT-1:0] CT_MINUS = {NCT{1'b1}};

  // Two's complement +1 / -1 selected by the programmed sign.
  function automatic logic [NCT-1:0] ct_of_sign(input logic sign);
    return sign ? CT_MINUS : CT_PLUS;
  endfunction

  // A countdown at zero fires and reloads period-1 so the next fire is P units later.
  function automatic gen_state_t gen_countdown(input gen_state_t g);
    gen_state_t r;
    r = g;
    if (g.ticks == '0) begin
      r.ticks = g.period - NPERIOD'(1);
    end else begin
      r.ticks = g.ticks - NPERIOD'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/spike_gen_mem.sv
// Generator state RAM: 2**AW entries of DW bits, one write port and one
// synchronous read port (data valid the cycle after the address). No reset;
// the controller clears contents with its INIT sweep.
//   clk      in  clock
//   we_i     in  write enable
//   waddr_i  in  write address
//   wdata_i  in  write data
//   raddr_i  in  read address
//   rdata_o  out registered read data
module spike_gen_mem
  import spike_gen_pkg::*;
#(
  parameter int AW = NGENS,
  parameter int DW = GEN_W
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spike_generator_core.sv
// Bank of 2**NGENS programmable periodic spike generators. On every time-unit
// pulse the controller scans generators 0..gens_used; each enabled generator
// whose countdown has expired emits one (tag, ct) word.
//   clk, reset_n                    clock, async active-low reset
//   gens_used, gens_en              highest scanned index, per-generator enable
//   time_unit                       one-cycle pulse per time unit
//   prog_gen_idx/period/ticks/tag/sign, prog_v/prog_a   programming channel
//   out_tag, out_ct, out_v/out_a    emitted word channel
//   missed_unit                     sticky: a time unit was dropped
module spike_generator_core
  import spike_gen_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NGENS-1:0]    gens_used,
  input  logic [NUM_GENS-1:0] gens_en,
  input  logic                time_unit,
  input  logic [NGENS-1:0]    prog_gen_idx,
  input  logic [NPERIOD-1:0]  prog_period,
  input  logic [NPERIOD-1:0]  prog_ticks,
  input  logic [NTAG-1:0]     prog_tag,
  input  logic                prog_sign,
  input  logic                prog_v,
  output logic                prog_a,
  output logic [NTAG-1:0]     out_tag,
  output logic [NCT-1:0]      out_ct,
  output logic                out_v,
  input  logic                out_a,
  output logic                missed_unit
);

  fsm_state_t       state_q;
  logic [NGENS-1:0] idx_q;
  logic             pending_q;
  logic             missed_q;
  logic             out_v_q;
  logic [NTAG-1:0]  out_tag_q;
  logic [NCT-1:0]   out_ct_q;

  logic             mem_we_s;
  logic [NGENS-1:0] mem_waddr_s;
  logic [GEN_W-1:0] mem_wdata_s;
  logic [GEN_W-1:0] mem_rdata_s;
  gen_state_t       rd_gen_s;
  gen_state_t       prog_gen_s;
  logic             gen_active_s;
  logic             gen_fire_s;
  logic             scan_last_s;
  logic             prog_ok_s;

  spike_gen_mem #(
    .AW (NGENS),
    .DW (GEN_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we_s),
    .waddr_i (mem_waddr_s),
    .wdata_i (mem_wdata_s),
    .raddr_i (idx_q),
    .rdata_o (mem_rdata_s)
  );

  assign rd_gen_s = mem_rdata_s;

  assign prog_gen_s.period = prog_period;
  assign prog_gen_s.ticks  = prog_ticks;
  assign prog_gen_s.tag    = prog_tag;
  assign prog_gen_s.sign   = prog_sign;

  // Enable and gens_used are looked at only while the read data is valid (UPD).
  assign gen_active_s = gens_en[idx_q] && (rd_gen_s.period != '0);
  assign gen_fire_s   = gen_active_s && (rd_gen_s.ticks == '0);
  assign scan_last_s  = (idx_q == gens_used);

  // Programming is accepted only in a quiet IDLE: a coincident time unit wins.
  assign prog_ok_s = (state_q == ST_IDLE) && !pending_q && !time_unit;
  assign prog_a    = prog_ok_s && prog_v;

  // Memory write-port steering: INIT clear, program write, countdown write-back.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = idx_q;
    mem_wdata_s = '0;
    case (state_q)
      ST_INIT: begin
        mem_we_s = 1'b1;
      end
      ST_IDLE: begin
        if (prog_ok_s && prog_v) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = prog_gen_idx;
          mem_wdata_s = prog_gen_s;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      ST_UPD: begin
        if (gen_active_s) begin
          mem_we_s    = 1'b1;
          mem_wdata_s = gen_countdown(rd_gen_s);
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Controller FSM with scan index, unit bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      idx_q     <= '0;
      pending_q <= 1'b0;
      missed_q  <= 1'b0;
      out_v_q   <= 1'b0;
      out_tag_q <= '0;
      out_ct_q  <= '0;
    end else begin
      // Units arriving while busy queue one deep; a second one is dropped.
      if (time_unit && (state_q != ST_IDLE)) begin
        if (pending_q) begin
          missed_q <= 1'b1;
        end else begin
          pending_q <= 1'b1;
        end
      end

      case (state_q)
        ST_INIT: begin
          if (idx_q == '1) begin
            idx_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            idx_q <= idx_q + NGENS'(1);
          end
        end
        ST_IDLE: begin
          if (pending_q) begin
            // The queued unit is consumed; a fresh pulse this cycle re-queues.
            pending_q <= time_unit;
            idx_q     <= '0;
            state_q   <= ST_RD;
          end else if (time_unit) begin
            idx_q   <= '0;
            state_q <= ST_RD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD: begin
          state_q <= ST_UPD;
        end
        ST_UPD: begin
          if (gen_fire_s) begin
            out_v_q   <= 1'b1;
            out_tag_q <= rd_gen_s.tag;
            out_ct_q  <= ct_of_sign(rd_gen_s.sign);
            state_q   <= ST_EMIT;
          end else if (scan_last_s) begin
            state_q <= ST_IDLE;
          end else begin
            idx_q   <= idx_q + NGENS'(1);
            state_q <= ST_RD;
          end
        end
        ST_EMIT: begin
          if (out_a) begin
            out_v_q <= 1'b0;
            if (scan_last_s) begin
              state_q <= ST_IDLE;
            end else begin
              idx_q   <= idx_q + NGENS'(1);
              state_q <= ST_RD;
            end
          end else begin
            state_q <= ST_EMIT;
          end
        end
        default: begin
          state_q <= ST_INIT;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign out_v       = out_v_q;
  assign out_tag     = out_tag_q;
  assign out_ct      = out_ct_q;
  assign missed_unit = missed_q;

endmodule

// File: tb/tb_spike_generator_core.sv
module tb_spike_generator_core;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [7:0]   gens_used;
  logic [255:0] gens_en;
  logic         time_unit;
  logic [7:0]   prog_gen_idx;
  logic [15:0]  prog_period;
  logic [15:0]  prog_ticks;
  logic [10:0]  prog_tag;
  logic         prog_sign;
  logic         prog_v;
  logic         prog_a;
  logic [10:0]  out_tag;
  logic [8:0]   out_ct;
  logic         out_v;
  logic         out_a;
  logic         missed_unit;

  int errors = 0;
  int checks = 0;

  logic [10:0] em_tag_q [$];
  logic [8:0]  em_ct_q  [$];

  spike_generator_core dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .gens_used    (gens_used),
    .gens_en      (gens_en),
    .time_unit    (time_unit),
    .prog_gen_idx (prog_gen_idx),
    .prog_period  (prog_period),
    .prog_ticks   (prog_ticks),
    .prog_tag     (prog_tag),
    .prog_sign    (prog_sign),
    .prog_v       (prog_v),
    .prog_a       (prog_a),
    .out_tag      (out_tag),
    .out_ct       (out_ct),
    .out_v        (out_v),
    .out_a        (out_a),
    .missed_unit  (missed_unit)
  );

  always #5 clk = ~clk;

  // Inputs change only at posedge+1, so a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_v === 1'b1 && out_a === 1'b1) begin
      em_tag_q.push_back(out_tag);
      em_ct_q.push_back(out_ct);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_unit();
    time_unit = 1'b1;
    tick(1);
    time_unit = 1'b0;
  endtask

  // One time unit followed by a quiet window; reports what was emitted in it.
  task automatic run_unit(input int spacing, output int n, output logic [10:0] tag, output logic [8:0] ct);
    em_tag_q.delete();
    em_ct_q.delete();
    pulse_unit();
    tick(spacing - 1);
    n   = em_tag_q.size();
    tag = (n > 0) ? em_tag_q[0] : 11'h000;
    ct  = (n > 0) ? em_ct_q[0] : 9'h000;
  endtask

  // Drives a program request until accepted; returns 0 if never accepted.
  task automatic prog(input logic [7:0] idx, input logic [15:0] per, input logic [15:0] tk,
                      input logic [10:0] tag, input logic sgn, output logic ok);
    prog_gen_idx = idx;
    prog_period  = per;
    prog_ticks   = tk;
    prog_tag     = tag;
    prog_sign    = sgn;
    prog_v       = 1'b1;
    ok           = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (prog_a === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    prog_v = 1'b0;
  endtask

  task automatic test_reset();
    int viol;
    reset_n      = 1'b0;
    prog_v       = 1'b1;
    prog_gen_idx = 8'h00;
    prog_period  = 16'h0000;
    prog_ticks   = 16'h0000;
    prog_tag     = 11'h000;
    prog_sign    = 1'b0;
    tick(3);
    @(negedge clk);
    checks++;
    if (out_v !== 1'b0 || out_tag !== 11'h000 || out_ct !== 9'h000) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b tag=%h ct=%h, want v=0 tag=000 ct=000", out_v, out_tag, out_ct);
    end
    checks++;
    if (prog_a !== 1'b0 || missed_unit !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got prog_a=%b missed=%b, want 0 0", prog_a, missed_unit);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (prog_a !== 1'b0 || out_v !== 1'b0) viol++;
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL init_busy: got %0d cycles with prog_a/out_v high during INIT, want 0", viol);
    end
    @(negedge clk);
    checks++;
    if (prog_a !== 1'b1) begin
      errors++;
      $display("FAIL init_done: got prog_a=%b after 256 INIT cycles, want 1", prog_a);
    end
    @(posedge clk);
    #1;
    prog_v = 1'b0;
    @(negedge clk);
    checks++;
    if (prog_a !== 1'b0) begin
      errors++;
      $display("FAIL prog_a_follow: got prog_a=%b with prog_v=0, want 0", prog_a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_periodic();
    logic ok;
    int n, exp_n;
    logic [10:0] t;
    logic [8:0] c;
    out_a      = 1'b1;
    gens_used  = 8'd3;
    gens_en    = '0;
    gens_en[3] = 1'b1;
    prog(8'd3, 16'd4, 16'd1, 11'h02A, 1'b0, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL periodic_prog: got accept=%b, want 1", ok);
    end
    for (int u = 1; u <= 11; u++) begin
      run_unit(50, n, t, c);
      exp_n = (u == 2 || u == 6 || u == 10) ? 1 : 0;
      checks++;
      if (n !== exp_n) begin
        errors++;
        $display("FAIL periodic_count u%0d: got %0d emissions, want %0d", u, n, exp_n);
      end
      if (exp_n == 1) begin
        checks++;
        if (t !== 11'h02A || c !== 9'h001) begin
          errors++;
          $display("FAIL periodic_word u%0d: got tag=%h ct=%h, want tag=02a ct=001", u, t, c);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic ok;
    int viol, n;
    logic [10:0] t;
    logic [8:0] c;
    prog(8'd3, 16'd4, 16'd0, 11'h02A, 1'b1, ok);
    out_a = 1'b0;
    em_tag_q.delete();
    em_ct_q.delete();
    pulse_unit();
    tick(19);
    @(negedge clk);
    checks++;
    if (out_v !== 1'b1 || out_tag !== 11'h02A || out_ct !== 9'h1FF) begin
      errors++;
      $display("FAIL stall_word: got v=%b tag=%h ct=%h, want v=1 tag=02a ct=1ff", out_v, out_tag, out_ct);
    end
    @(posedge clk);
    #1;
    pulse_unit();
    tick(5);
    @(negedge clk);
    checks++;
    if (missed_unit !== 1'b0) begin
      errors++;
      $display("FAIL stall_pending: got missed=%b after one queued unit, want 0", missed_unit);
    end
    @(posedge clk);
    #1;
    pulse_unit();
    tick(5);
    @(negedge clk);
    checks++;
    if (missed_unit !== 1'b1) begin
      errors++;
      $display("FAIL stall_missed: got missed=%b after second queued unit, want 1", missed_unit);
    end
    viol = 0;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      if (out_v !== 1'b1 || out_tag !== 11'h02A || out_ct !== 9'h1FF) viol++;
    end
    checks++;
    if (viol !== 0 || em_tag_q.size() !== 0) begin
      errors++;
      $display("FAIL stall_stable: got %0d unstable cycles, %0d transfers, want 0 0", viol, em_tag_q.size());
    end
    @(posedge clk);
    #1;
    out_a = 1'b1;
    tick(40);
    @(negedge clk);
    checks++;
    if (em_tag_q.size() !== 1 || out_v !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept: got %0d transfers v=%b, want 1 transfer v=0", em_tag_q.size(), out_v);
    end
    @(posedge clk);
    #1;
    // The queued unit ran a scan after the accept (ticks 3->2), so the next fire is the 3rd unit.
    for (int u = 1; u <= 3; u++) begin
      run_unit(30, n, t, c);
      checks++;
      if (n !== ((u == 3) ? 1 : 0)) begin
        errors++;
        $display("FAIL stall_phase u%0d: got %0d emissions, want %0d", u, n, (u == 3) ? 1 : 0);
      end
    end
    checks++;
    if (c !== 9'h1FF || missed_unit !== 1'b1) begin
      errors++;
      $display("FAIL stall_after: got ct=%h missed=%b, want ct=1ff missed=1", c, missed_unit);
    end
  endtask

  task automatic test_gens_used();
    logic ok;
    int n, exp_n;
    logic [10:0] t;
    logic [8:0] c;
    gens_en    = '0;
    gens_en[5] = 1'b1;
    gens_used  = 8'd4;
    prog(8'd5, 16'd1, 16'd0, 11'h055, 1'b0, ok);
    for (int u = 1; u <= 3; u++) begin
      run_unit(30, n, t, c);
      checks++;
      if (n !== 0) begin
        errors++;
        $display("FAIL used_excluded u%0d: got %0d emissions, want 0", u, n);
      end
    end
    gens_used = 8'd5;
    for (int u = 1; u <= 3; u++) begin
      run_unit(30, n, t, c);
      checks++;
      if (n !== 1 || t !== 11'h055 || c !== 9'h001) begin
        errors++;
        $display("FAIL used_included u%0d: got n=%0d tag=%h ct=%h, want n=1 tag=055 ct=001", u, n, t, c);
      end
    end
    // Period 3: fires at unit 1; disabled for units 3..5 freezes the countdown, so next fire is unit 7.
    prog(8'd5, 16'd3, 16'd0, 11'h055, 1'b0, ok);
    for (int u = 1; u <= 8; u++) begin
      gens_en[5] = !(u >= 3 && u <= 5);
      run_unit(30, n, t, c);
      exp_n = (u == 1 || u == 7) ? 1 : 0;
      checks++;
      if (n !== exp_n) begin
        errors++;
        $display("FAIL enable_phase u%0d: got %0d emissions, want %0d", u, n, exp_n);
      end
    end
  endtask

  task automatic test_period_zero();
    logic ok, first_a;
    int n, total, waited;
    logic [10:0] t;
    logic [8:0] c;
    gens_en    = '0;
    gens_en[7] = 1'b1;
    gens_used  = 8'd7;
    prog(8'd7, 16'd0, 16'd0, 11'h077, 1'b0, ok);
    total = 0;
    for (int u = 0; u < 20; u++) begin
      run_unit(30, n, t, c);
      total += n;
    end
    checks++;
    if (total !== 0) begin
      errors++;
      $display("FAIL period_zero: got %0d emissions over 20 units, want 0", total);
    end
    time_unit    = 1'b1;
    prog_gen_idx = 8'd7;
    prog_period  = 16'd2;
    prog_ticks   = 16'd0;
    prog_tag     = 11'h077;
    prog_sign    = 1'b0;
    prog_v       = 1'b1;
    ok      = 1'b0;
    waited  = 0;
    first_a = 1'bx;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (i == 0) first_a = prog_a;
      if (prog_a === 1'b1) ok = 1'b1;
      else waited++;
      @(posedge clk);
      #1;
      time_unit = 1'b0;
    end
    prog_v = 1'b0;
    checks++;
    if (first_a !== 1'b0) begin
      errors++;
      $display("FAIL collide_prog_a: got prog_a=%b with time_unit, want 0", first_a);
    end
    // Collision cycle plus an 8-generator scan of 2 cycles each.
    checks++;
    if (ok !== 1'b1 || waited !== 17) begin
      errors++;
      $display("FAIL collide_accept: got accept=%b after %0d cycles, want 1 after 17", ok, waited);
    end
    run_unit(30, n, t, c);
    checks++;
    if (n !== 1 || t !== 11'h077 || c !== 9'h001) begin
      errors++;
      $display("FAIL collide_fire: got n=%0d tag=%h ct=%h, want n=1 tag=077 ct=001", n, t, c);
    end
  endtask

  task automatic test_reset_mid_emit();
    int n, total;
    logic [10:0] t;
    logic [8:0] c;
    out_a = 1'b0;
    run_unit(30, n, t, c);
    pulse_unit();
    tick(29);
    @(negedge clk);
    checks++;
    if (out_v !== 1'b1) begin
      errors++;
      $display("FAIL emit_setup: got out_v=%b, want 1", out_v);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_v !== 1'b0 || missed_unit !== 1'b0 || out_tag !== 11'h000 || out_ct !== 9'h000) begin
      errors++;
      $display("FAIL async_reset: got v=%b missed=%b tag=%h ct=%h, want all 0", out_v, missed_unit, out_tag, out_ct);
    end
    tick(2);
    reset_n   = 1'b1;
    out_a     = 1'b1;
    gens_en   = '1;
    gens_used = 8'hFF;
    tick(260);
    total = 0;
    for (int u = 0; u < 2; u++) begin
      run_unit(600, n, t, c);
      total += n;
    end
    checks++;
    if (total !== 0) begin
      errors++;
      $display("FAIL reinit_cleared: got %0d emissions after reset, want 0", total);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    gens_used    = 8'd0;
    gens_en      = '0;
    time_unit    = 1'b0;
    prog_gen_idx = 8'd0;
    prog_period  = 16'd0;
    prog_ticks   = 16'd0;
    prog_tag     = 11'd0;
    prog_sign    = 1'b0;
    prog_v       = 1'b0;
    out_a        = 1'b1;
    tick(1);
    test_reset();
    test_periodic();
    test_stall();
    test_gens_used();
    test_period_zero();
    test_reset_mid_emit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
